// File: rtl/fifo_pkg.sv
// Shared helpers for FIFO pointer sizing and parameter checks.
package fifo_pkg;

   // Pointer width: address bits plus one wrap bit.
   function automatic int ptr_w(int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(int value);
      return (value >= 2) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; slave is the FIFO side.
interface sync_fifo_if
   import fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
);
   localparam int CntW = ptr_w(DEPTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CntW-1:0]  count;
   logic             almost_full;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count, almost_full
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count, almost_full
   );
endinterface

// File: rtl/dual_port_RAM.sv
// Storage primitive: synchronous write port, combinational read port.
module dual_port_RAM #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     wclk,
   input  logic                     wenc,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     rclk,
   input  logic                     renc,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Read is asynchronous, so the read clock has no load.
   logic unused_rclk;
   assign unused_rclk = rclk;

   always_ff @(posedge wclk) begin
      if (wenc) mem[waddr] <= wdata;
   end

   assign rdata = renc ? mem[raddr] : '0;
endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: pointer control around dual_port_RAM.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned AFULL_LVL = DEPTH - 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   sync_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW-1:0] AfullLvl = PW'(AFULL_LVL);

   initial assert (is_pow2(DEPTH)) else $fatal(1, "sync_fifo: DEPTH must be a power of two >= 2");

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          full, empty, push, pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign bus.in_ready    = !full;
   assign bus.out_valid   = !empty;
   assign push            = bus.in_valid & bus.in_ready;
   assign pop             = bus.out_valid & bus.out_ready;
   assign bus.count       = wr_ptr_q - rd_ptr_q;
   assign bus.almost_full = (bus.count >= AfullLvl);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // A write during flush lands in RAM but the pointer never covers it.
   dual_port_RAM #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_ram (
      .wclk  (clk),
      .wenc  (push),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (bus.in_data),
      .rclk  (clk),
      .renc  (1'b1),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (bus.out_data)
   );
endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random stimulus for sync_fifo against a queue reference model.
module tb_sync_fifo;
   localparam int DEPTH = 16;
   localparam int WIDTH = 8;
   localparam int AFULL = DEPTH - 2;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] model_q [$];
   bit               known = 1'b0;

   sync_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

   sync_fifo #(
      .DEPTH     (DEPTH),
      .WIDTH     (WIDTH),
      .AFULL_LVL (AFULL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: compare outputs with the model, drive inputs, advance the model.
   task automatic cycle(input bit rst, input bit fl, input bit iv, input logic [WIDTH-1:0] d,
                        input bit ordy);
      int sz;
      @(negedge clk);
      sz = model_q.size();
      if (known) begin
         check_val("in_ready", 32'(bus.in_ready), 32'(sz < DEPTH));
         check_val("out_valid", 32'(bus.out_valid), 32'(sz > 0));
         check_val("count", 32'(bus.count), 32'(sz));
         check_val("almost_full", 32'(bus.almost_full), 32'(sz >= AFULL));
         if (sz > 0) check_val("out_data", 32'(bus.out_data), 32'(model_q[0]));
      end
      rst_n         = ~rst;
      flush         = fl;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      if (rst || fl) begin
         model_q.delete();
         known = 1'b1;
      end else if (known) begin
         if (ordy && sz > 0) void'(model_q.pop_front());
         if (iv && sz < DEPTH) model_q.push_back(d);
      end
      @(posedge clk);
   endtask

   initial begin
      bit               pend;
      logic [WIDTH-1:0] pdata;
      bit               iv, ordy, fl;
      logic [WIDTH-1:0] d;

      rst_n = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

      // Reset then idle
      repeat (2) cycle(1, 0, 0, 8'h00, 0);
      repeat (5) cycle(0, 0, 0, 8'h00, 0);

      // Fill, then pop at full with a held push, then drain
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'(i), 0);
      cycle(0, 0, 1, 8'h10, 1);
      cycle(0, 0, 1, 8'h10, 1);
      repeat (DEPTH + 2) cycle(0, 0, 0, 8'h00, 1);

      // Streaming across two pointer wraps
      for (int i = 0; i < 40; i++) cycle(0, 0, 1, 8'(8'h40 + i), 1);
      repeat (3) cycle(0, 0, 0, 8'h00, 1);

      // Flush mid-stream with a concurrent push
      for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'h20 + i), 0);
      cycle(0, 1, 1, 8'hAA, 0);
      cycle(0, 0, 0, 8'h00, 0);
      cycle(0, 0, 1, 8'h55, 0);
      repeat (2) cycle(0, 0, 0, 8'h00, 0);
      cycle(0, 0, 0, 8'h00, 1);

      // Reset wins over flush while a push is active
      for (int i = 0; i < 7; i++) cycle(0, 0, 1, 8'(8'h70 + i), 0);
      cycle(1, 1, 1, 8'hEE, 1);
      repeat (2) cycle(0, 0, 0, 8'h00, 0);

      // Random traffic; a stalled push keeps its data until accepted
      pend = 1'b0; pdata = '0;
      for (int n = 0; n < 3000; n++) begin
         if (pend) begin
            iv = 1'b1; d = pdata;
         end else begin
            iv = ($urandom_range(0, 99) < 60);
            d  = 8'($urandom);
         end
         ordy = ($urandom_range(0, 99) < 45);
         fl   = ($urandom_range(0, 199) == 0);
         pend  = iv && !fl && (model_q.size() >= DEPTH);
         pdata = d;
         cycle(0, fl, iv, d, ordy);
      end
      cycle(0, 0, 0, 8'h00, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-word-fall-through FIFO built around the existing `dual_port_RAM` storage primitive. It supplies the write-side and read-side pointer control that the RAM lacks: valid/ready handshakes on both ends, occupancy tracking, and a synchronous flush. It sits between cache pipeline stages, for example refill and writeback queues, wherever a producer and a consumer in the same clock domain need decoupling.

## Interface
Parameters:
- `DEPTH`, default 16: number of entries. Must be a power of two and at least 2.
- `WIDTH`, default 8: data width in bits.
- `AFULL_LVL`, default `DEPTH-2`: the occupancy at or above which `almost_full` is asserted.

Ports (one clock; reset is synchronous and active-low):
- `clk` (input, 1): sole clock. All state updates on its rising edge.
- `rst_n` (input, 1): synchronous reset, active-low.
- `flush` (input, 1): synchronous clear of all entries.
- `in_valid` (input, 1): producer presents `in_data`.
- `in_ready` (output, 1): the FIFO can accept an entry this cycle.
- `in_data` (input, `WIDTH`): write data.
- `out_valid` (output, 1): `out_data` holds the oldest entry.
- `out_ready` (input, 1): consumer takes the head entry this cycle.
- `out_data` (output, `WIDTH`): head entry.
- `count` (output, `$clog2(DEPTH)+1`): current occupancy, 0 to `DEPTH`.
- `almost_full` (output, 1): asserted when `count >= AFULL_LVL`.

## Operation
- Pointers `wr_ptr` and `rd_ptr` are each `$clog2(DEPTH)+1` bits wide. The MSB is the wrap bit.
  - empty = (`wr_ptr == rd_ptr`).
  - full = low bits equal and MSBs differ.
- Handshakes:
  - push = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
  - `in_ready = !full`. There is no pass-through when full: a pop in the same cycle does not raise `in_ready`.
  - `out_valid = !empty`. There is no bypass when empty: a push into an empty FIFO becomes visible on the next cycle.
- On push, the RAM is written at `wr_ptr[low]` and `wr_ptr` increments by 1, wrapping modulo `2*DEPTH`.
- On pop, `rd_ptr` increments by 1, wrapping the same way.
- `out_data` is the RAM's combinational read at `rd_ptr[low]`.
- Simultaneous push and pop (legal only when neither full nor empty): both pointers advance and `count` is unchanged.
- `count = wr_ptr - rd_ptr` (modulo arithmetic). It is a registered pointer difference, with no separate counter.
- `flush` clears both pointers to 0. A push or pop in the same cycle is ignored. RAM contents are not cleared.
- `rst_n` low takes priority over `flush`.
- The producer must hold `in_data` stable while `in_valid` is high and `in_ready` is low. `in_valid` must not drop before the handshake completes. The bench checks this; the RTL does not.

## Timing
- Reset, on the rising edge with `rst_n == 0`:
  - `wr_ptr`, `rd_ptr` = 0.
  - `in_ready` = 1, `out_valid` = 0, `count` = 0.
  - `almost_full` = 0 (for `AFULL_LVL > 0`).
  - `out_data` is undefined until the first push.
- Latency: a push in cycle N gives `out_valid = 1` and the data on `out_data` in cycle N+1.
- Pop: the head advances on the edge ending cycle N, and the next entry appears in N+1 with no bubble.
- Full boundary: the push that brings `count` to `DEPTH` drops `in_ready` in the following cycle. A pop in cycle N raises `in_ready` in N+1.
- Empty boundary: the pop of the last entry drops `out_valid` in the following cycle.
- Wrap-around: the low pointer bits roll from `DEPTH-1` to 0 and the MSB toggles. full/empty remain correct across unlimited wraps.
- Reset or flush mid-stream: the FIFO is empty from the next cycle. Any handshake in the reset/flush cycle is discarded.

## Structure
- Instantiate one `dual_port_RAM #(.DEPTH(DEPTH), .WIDTH(WIDTH))` with:
  - `wclk = rclk = clk`.
  - `wenc = push`, `renc = 1'b1`.
  - `waddr = wr_ptr[low]`, `raddr = rd_ptr[low]`.
- Put pointer control in this module. No further sub-module is needed.
- Shared package `fifo_pkg`:
  - `function automatic int ptr_w(int depth)`, returning `$clog2(depth)+1`.
  - A generic elaboration-time check that `DEPTH` is a power of two, used here through an `initial` assertion.

## Test plan
- Reset then idle: hold `rst_n = 0` for 2 cycles, then release. Expect `in_ready = 1`, `out_valid = 0`, `count = 0` and `almost_full = 0` for 5 idle cycles.
- Fill and drain (DEPTH=16):
  - Push 0x00 to 0x0F back-to-back with `out_ready = 0`. `in_ready` drops after the 16th push, `count = 16`, and `almost_full` asserts once `count` reaches 14.
  - Then set `out_ready = 1`. Read 0x00 to 0x0F in order on consecutive cycles, and `out_valid` drops after the last.
- Streaming across wrap: hold `in_valid = out_ready = 1` for 40 cycles with an incrementing data pattern. `count` stays at 1 after the first cycle, the output sequence equals the input sequence delayed by 1 cycle, and the pointers wrap twice.
- Full with simultaneous pop: at `count = 16`, assert `in_valid` and `out_ready` together. Expect no push that cycle, the pop to occur, `count = 15`, and `in_ready = 1` on the next cycle.
- Flush mid-stream: at `count = 5`, assert `flush` together with a push of 0xAA. The next cycle shows `count = 0` and `out_valid = 0`. A later push of 0x55 appears as the head with `count = 1`.
- Reset priority: assert `rst_n = 0` and `flush = 1` at `count = 7` with a push active. Expect all outputs at their reset values on the next cycle.
